// File: rtl/conv_pkg.sv
// Shared types, defaults and parity helper for the rate-1/2 convolutional frame sequencer.
package conv_pkg;

    localparam int unsigned CONSTR_LEN_DEF = 3;
    localparam logic [2:0]  G0_DEF         = 3'b111;
    localparam logic [2:0]  G1_DEF         = 3'b101;
    localparam int unsigned CONV_MAX_K     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } conv_state_e;

    typedef struct packed {
        logic y0;
        logic y1;
    } conv_pair_t;

    function automatic logic conv_parity(input logic [CONV_MAX_K-1:0] vec,
                                         input logic [CONV_MAX_K-1:0] gen);
        return ^(vec & gen);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Convolutional encoder core: K-1 bit shift memory and registered coded pair per shift.
module conv_enc_core
    import conv_pkg::*;
#(
    parameter int unsigned           CONSTR_LEN = CONSTR_LEN_DEF,
    parameter logic [CONSTR_LEN-1:0] G0         = CONSTR_LEN'(G0_DEF),
    parameter logic [CONSTR_LEN-1:0] G1         = CONSTR_LEN'(G1_DEF)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_i,
    input  logic       bit_i,
    input  logic       clr_i,
    output conv_pair_t pair_o
);

    localparam int unsigned MW = CONSTR_LEN - 1;

    logic [MW-1:0]         mem_q, mem_d;
    conv_pair_t            pair_q, pair_d;
    logic [CONSTR_LEN-1:0] vec_c;

    // Newest bit sits at the top of the vector; memory drops its oldest bit on a shift.
    always_comb begin
        vec_c  = {bit_i, mem_q};
        mem_d  = mem_q;
        pair_d = pair_q;
        if (shift_i) begin
            pair_d.y0 = conv_parity(CONV_MAX_K'(vec_c), CONV_MAX_K'(G0));
            pair_d.y1 = conv_parity(CONV_MAX_K'(vec_c), CONV_MAX_K'(G1));
            mem_d     = vec_c[CONSTR_LEN-1:1];
        end
        if (clr_i) begin
            mem_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            pair_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pair_q <= pair_d;
        end
    end

    assign pair_o = pair_q;

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: paces the encoder at one info bit per two clocks, appends tail bits, serializes pairs.
// Define CONV_FRAME_CNT_EN to add the 16-bit completed-frame counter output frame_cnt.
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned           FRAME_LEN  = 16,
    parameter int unsigned           CONSTR_LEN = CONSTR_LEN_DEF,
    parameter logic [CONSTR_LEN-1:0] G0         = CONSTR_LEN'(G0_DEF),
    parameter logic [CONSTR_LEN-1:0] G1         = CONSTR_LEN'(G1_DEF)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic        out_valid,
    output logic        out_bit,
    output logic        out_sof,
    output logic        out_eof,
    output logic        busy
`ifdef CONV_FRAME_CNT_EN
   ,output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned BW = $clog2(FRAME_LEN + 1);
    localparam int unsigned TW = $clog2(CONSTR_LEN);

    conv_state_e   state_q, state_d;
    logic          phase_q, phase_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tail_cnt_q, tail_cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          out_sof_q, out_sof_d;
    logic          out_eof_q, out_eof_d;
    logic          eof_pend_q, eof_pend_d;
    logic          busy_q, busy_d;

    logic          accept_c;
    logic          inject_c;
    logic          shift_c;
    logic          enc_bit_c;
    logic          last_inj_c;
    conv_pair_t    pair;

    conv_enc_core #(
        .CONSTR_LEN (CONSTR_LEN),
        .G0         (G0),
        .G1         (G1)
    ) u_enc (
        .clk     (clk),
        .rst     (rst),
        .shift_i (shift_c),
        .bit_i   (enc_bit_c),
        .clr_i   (last_inj_c),
        .pair_o  (pair)
    );

    // Next state, counters and registered output flags.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tail_cnt_d = tail_cnt_q;
        last_inj_c = 1'b0;

        accept_c   = in_valid & in_ready_q;
        inject_c   = (state_q == TAIL) & ~phase_q;
        shift_c    = accept_c | inject_c;
        enc_bit_c  = accept_c & in_bit;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    bit_cnt_d = BW'(1);
                    state_d   = (FRAME_LEN == 1) ? TAIL : DATA;
                end
            end
            DATA: begin
                if (accept_c) begin
                    if (bit_cnt_q == BW'(FRAME_LEN - 1)) begin
                        state_d = TAIL;
                    end
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            TAIL: begin
                if (inject_c) begin
                    if (tail_cnt_q == TW'(CONSTR_LEN - 2)) begin
                        state_d    = IDLE;
                        tail_cnt_d = '0;
                        bit_cnt_d  = '0;
                        last_inj_c = 1'b1;
                    end else begin
                        tail_cnt_d = tail_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Phase=1 marks the y0 cycle; a shift can only happen with phase=0.
        phase_d     = shift_c;
        out_valid_d = shift_c | phase_q;
        out_sof_d   = accept_c & (state_q == IDLE);
        eof_pend_d  = last_inj_c;
        out_eof_d   = eof_pend_q;
        in_ready_d  = ((state_d == IDLE) | (state_d == DATA)) & ~phase_d;
        busy_d      = (state_d != IDLE) | out_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            bit_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            eof_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            eof_pend_q  <= eof_pend_d;
            busy_q      <= busy_d;
        end
    end

`ifdef CONV_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Counts a frame on the edge that ends its out_eof cycle; wraps naturally.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (out_eof_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    // y0 is presented while phase=1, y1 on the following cycle.
    assign out_bit   = out_valid_q & (phase_q ? pair.y0 : pair.y1);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign busy      = busy_q;

endmodule
